cache_port_arbiter: RTL and testbench

//  Shares the single-ported data cache / write-through main-memory path between the

---
 rtl/cache_port_arbiter.sv | 128 ++++++++++++
 tb/tb_cache_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// Arbitrates the data and fetch requesters onto one cache/memory backend path.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of data-first priority.
module cache_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MISS_LAT = 4,
   parameter int WR_LAT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_mask,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_done,
   output logic              f_stall,
   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_wdata,
   output logic [2:0]        c_mask,
   output logic              c_read,
   output logic              c_write,
   input  logic [DATA_W-1:0] c_rdata,
   input  logic              c_hit
);
   localparam int MAX_LAT = (MISS_LAT > WR_LAT) ? MISS_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             gnt_f;
   logic             lat_we;
   logic             pick_f;
   logic             complete;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_f;
   // On a tie the port that did not win last time gets the grant.
   always_comb pick_f = f_req & (~d_req | ~last_f);
`else
   always_comb pick_f = f_req & ~d_req;
`endif

   // Read data is ready on an ACCESS hit or in the final WAIT cycle.
   always_comb complete = ((state == ACCESS) & ~lat_we & c_hit) |
                          ((state == WAIT) & (cnt == CNT_W'(1)));

   assign d_stall = d_req & ~d_done;
   assign f_stall = f_req & ~f_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         gnt_f   <= 1'b0;
         lat_we  <= 1'b0;
         d_rdata <= '0;
         d_done  <= 1'b0;
         f_rdata <= '0;
         f_done  <= 1'b0;
         c_addr  <= '0;
         c_wdata <= '0;
         c_mask  <= '0;
         c_read  <= 1'b0;
         c_write <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_f  <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (d_req | f_req) begin
                  gnt_f   <= pick_f;
                  lat_we  <= ~pick_f & d_we;
                  c_addr  <= pick_f ? f_addr : d_addr;
                  c_wdata <= pick_f ? '0 : d_wdata;
                  c_mask  <= pick_f ? 3'b010 : d_mask;
                  c_read  <= pick_f | ~d_we;
                  c_write <= ~pick_f & d_we;
                  state   <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                  last_f  <= pick_f;
`endif
               end
            end
            ACCESS: begin
               // The write strobe lasts one cycle so the backend sees exactly one write.
               c_write <= 1'b0;
               if (lat_we) begin
                  cnt   <= CNT_W'(WR_LAT);
                  state <= WAIT;
               end else if (!c_hit) begin
                  cnt   <= CNT_W'(MISS_LAT);
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= RESP;
            end
            RESP: begin
               d_done  <= 1'b0;
               f_done  <= 1'b0;
               d_rdata <= '0;
               f_rdata <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (complete) begin
            state   <= RESP;
            c_read  <= 1'b0;
            d_done  <= ~gnt_f;
            f_done  <= gnt_f;
            d_rdata <= (~gnt_f & ~lat_we) ? c_rdata : '0;
            f_rdata <= gnt_f ? c_rdata : '0;
         end
      end
   end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: vector table with scoreboard plus tie,
// reset-abort and withdrawn-request sequences. Honours ARB_ROUND_ROBIN_EN if defined.
module tb_cache_port_arbiter;
   localparam int MISS_LAT = 4;
   localparam int WR_LAT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        d_req, d_we, f_req, c_hit;
   logic [31:0] d_addr, d_wdata, f_addr, c_rdata;
   logic [2:0]  d_mask;
   logic [31:0] d_rdata, f_rdata, c_addr, c_wdata;
   logic [2:0]  c_mask;
   logic        d_done, d_stall, f_done, f_stall, c_read, c_write;

   cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MISS_LAT(MISS_LAT), .WR_LAT(WR_LAT)) dut (
      .clk(clk), .reset(reset),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
      .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done), .f_stall(f_stall),
      .c_addr(c_addr), .c_wdata(c_wdata), .c_mask(c_mask), .c_read(c_read), .c_write(c_write),
      .c_rdata(c_rdata), .c_hit(c_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_f;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mask;
      logic        hit;
      logic [31:0] rdata;
      int          lat;
      int          rd_cyc;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic        is_f;
      logic [31:0] rdata;
      int          lat;
   } sb_t;

   vec_t vecs[6];
   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_mask = '0;
      f_req = 0; f_addr = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask

   // Compare one completion against the oldest scoreboard entry.
   task automatic score(input string tag, input logic is_f, input logic [31:0] rdata, input int lat);
      sb_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_port"}, {31'd0, is_f}, {31'd0, e.is_f});
         check({tag, "_rdata"}, rdata, e.rdata);
         check({tag, "_latency"}, lat, e.lat);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int rd_cyc = 0, wr_cyc = 0, bus_bad = 0, stall_bad = 0, wrong = 0, lat = -1;
      sb_t e;
      @(posedge clk); #1;
      c_hit = v.hit; c_rdata = v.rdata;
      if (v.is_f) begin
         f_req = 1; f_addr = v.addr;
      end else begin
         d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_mask = v.mask;
      end
      e.is_f = v.is_f; e.rdata = v.exp_rdata; e.lat = v.lat;
      sb_q.push_back(e);
      for (int n = 0; n < 20 && lat < 0; n++) begin
         @(negedge clk);
         if (c_read) begin
            rd_cyc++;
            if (c_addr !== v.addr || c_mask !== (v.is_f ? 3'b010 : v.mask)) bus_bad++;
         end
         if (c_write) begin
            wr_cyc++;
            if (c_addr !== v.addr || c_wdata !== v.wdata || c_mask !== v.mask) bus_bad++;
         end
         if (v.is_f ? d_done : f_done) wrong++;
         if (v.is_f ? f_done : d_done) begin
            lat = n;
            score(tag, v.is_f, v.is_f ? f_rdata : d_rdata, n);
            check({tag, "_stall_at_done"}, {31'd0, v.is_f ? f_stall : d_stall}, 32'd0);
            check({tag, "_other_rdata"}, v.is_f ? d_rdata : f_rdata, 32'd0);
         end else if ((v.is_f ? f_stall : d_stall) !== 1'b1) begin
            stall_bad++;
         end
      end
      if (lat < 0) begin
         check({tag, "_timeout"}, 32'd1, 32'd0);
         void'(sb_q.pop_front());
      end
      idle_inputs();
      check({tag, "_read_cycles"}, rd_cyc, v.rd_cyc);
      check({tag, "_write_cycles"}, wr_cyc, v.we ? 32'd1 : 32'd0);
      check({tag, "_bus_fields"}, bus_bad, 32'd0);
      check({tag, "_stall_before_done"}, stall_bad, 32'd0);
      check({tag, "_other_done"}, wrong, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   got, dn, lat, rd_cyc, bad;
      logic exp_f[4];
      sb_t  e;

      vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        3'b000, 1'b1, 32'h00500093, 2, 1,            32'h00500093};
      vecs[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF, 2 + MISS_LAT, MISS_LAT + 1, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 1'b1, 32'h200, 32'h12345678, 3'b010, 1'b0, 32'hAAAA5555, 2 + WR_LAT, 0,    32'h0};
      vecs[3] = '{1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 3'b000, 1'b1, 32'h5555AAAA, 2 + WR_LAT, 0,    32'h0};
      vecs[4] = '{1'b0, 1'b0, 32'h300, 32'h0,        3'b100, 1'b1, 32'h000000FF, 2, 1,            32'h000000FF};
      vecs[5] = '{1'b1, 1'b0, 32'h80,  32'h0,        3'b000, 1'b0, 32'h00000013, 2 + MISS_LAT, MISS_LAT + 1, 32'h00000013};

      reset = 1; idle_inputs(); c_hit = 0; c_rdata = '0;
      repeat (2) @(negedge clk);
      check("reset_strobes", {28'd0, c_read, c_write, d_done, f_done}, 32'd0);
      check("reset_c_addr", c_addr, 32'd0);
      check("reset_rdata", d_rdata | f_rdata | c_wdata, 32'd0);
      check("reset_mask", {29'd0, c_mask}, 32'd0);
      reset = 0;

      for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Both ports held high with hits: grant order depends on the arbitration build.
      pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
      exp_f = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_f = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 4; i++) begin
         e.is_f = exp_f[i]; e.rdata = 32'h0000_0055; e.lat = 0;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      c_hit = 1; c_rdata = 32'h55;
      d_req = 1; d_we = 0; d_addr = 32'h10; d_mask = 3'b010;
      f_req = 1; f_addr = 32'h20;
      got = 0;
      for (int n = 0; n < 40 && got < 4; n++) begin
         @(negedge clk);
         if (d_done && f_done) check("tie_both_done", 32'd1, 32'd0);
         else if (d_done || f_done) begin
            score($sformatf("tie%0d", got), f_done, f_done ? f_rdata : d_rdata, 0);
            got++;
         end
      end
      check("tie_grants", got, 32'd4);
      while (sb_q.size() > 0) void'(sb_q.pop_front());
      idle_inputs();
      repeat (2) @(negedge clk);

      // Asynchronous reset in the second WAIT cycle of a load miss aborts it.
      @(posedge clk); #1;
      c_hit = 0; c_rdata = 32'hDEADBEEF;
      d_req = 1; d_we = 0; d_addr = 32'h100; d_mask = 3'b010;
      repeat (4) @(negedge clk);
      check("abort_read_before", {31'd0, c_read}, 32'd1);
      reset = 1;
      #1;
      check("abort_read_dropped", {31'd0, c_read}, 32'd0);
      d_req = 0;
      @(negedge clk);
      reset = 0;
      dn = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (d_done || f_done || c_read || c_write) dn++;
      end
      check("abort_no_activity", dn, 32'd0);
      run_vec("after_reset", vecs[0]);

      // Fetch miss whose request drops in the ACCESS cycle still completes once.
      @(posedge clk); #1;
      c_hit = 0; c_rdata = 32'h00000077;
      f_req = 1; f_addr = 32'h80;
      e.is_f = 1'b1; e.rdata = 32'h77; e.lat = 2 + MISS_LAT;
      sb_q.push_back(e);
      dn = 0; lat = -1; rd_cyc = 0; bad = 0;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (n == 1) f_req = 0;
         if (c_read) rd_cyc++;
         if (d_done) bad++;
         if (f_done) begin
            dn++;
            if (lat < 0) begin
               lat = n;
               score("withdrawn", 1'b1, f_rdata, n);
            end
         end
      end
      check("withdrawn_done_count", dn, 32'd1);
      check("withdrawn_read_cycles", rd_cyc, MISS_LAT + 1);
      check("withdrawn_d_done", bad, 32'd0);
      if (lat < 0) check("withdrawn_timeout", 32'd1, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
